// File: rtl/coin_pulse_tx_if.sv
// Coin/accept link between the coin front end and the credit FSM.
// The coin front end is the master: it reads the sensor, denomination
// and current credit, and drives the strobes and status flags.
interface coin_pulse_tx_if;
    logic       coin_sense;
    logic [1:0] coin_val;
    logic [2:0] credit_in;
    logic       m;
    logic       a;
    logic       reject;
    logic       ready;
    logic       overrun;

    modport master (
        input  coin_sense, coin_val, credit_in,
        output m, a, reject, ready, overrun
    );

    modport slave (
        output coin_sense, coin_val, credit_in,
        input  m, a, reject, ready, overrun
    );
endinterface

// File: rtl/coin_pulse_tx.sv
// Coin mechanism front end: synchronises and debounces the coin sensor,
// validates the coin against the current credit and then emits one m/a
// strobe pair per credit unit. A coin is never credited twice.
module coin_pulse_tx #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int CREDIT_MAX      = 7
) (
    input  logic              clk,
    input  logic              reset,
    coin_pulse_tx_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MARK,
        ACK,
        GAP,
        REJECT,
        WAIT_REL
    } state_t;

    localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] GAP_LAST   = (GAP_CYCLES == 0) ? 3'd0 : 3'(GAP_CYCLES - 1);
    localparam logic [3:0] CREDIT_LIM = 4'(CREDIT_MAX);

    logic       sync1_q;
    logic       sync2_q;
    logic       deb_q;
    logic       debPrev_q;
    logic [3:0] cnt_q;

    state_t     state_q, state_d;
    logic [1:0] val_q, val_d;
    logic [1:0] units_q, units_d;
    logic [2:0] gapCnt_q, gapCnt_d;
    logic       overrun_q, overrun_d;
    logic       m_q, a_q, reject_q, ready_q;

    logic       coinEvent;
    logic [3:0] sum;

    // Two-flop synchroniser followed by a stable-count debouncer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            debPrev_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            sync1_q   <= bus.coin_sense;
            sync2_q   <= sync1_q;
            debPrev_q <= deb_q;
            if (sync2_q == deb_q) begin
                cnt_q <= 4'd0;
            end else if (cnt_q == DEB_LAST) begin
                deb_q <= sync2_q;
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign coinEvent = deb_q && !debPrev_q;
    assign sum       = {1'b0, bus.credit_in} + {2'b00, val_q};

    // State register plus outputs registered from the next state, so every
    // strobe lines up with the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            val_q     <= 2'd0;
            units_q   <= 2'd0;
            gapCnt_q  <= 3'd0;
            overrun_q <= 1'b0;
            m_q       <= 1'b0;
            a_q       <= 1'b0;
            reject_q  <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            units_q   <= units_d;
            gapCnt_q  <= gapCnt_d;
            overrun_q <= overrun_d;
            m_q       <= (state_d == MARK);
            a_q       <= (state_d == ACK);
            reject_q  <= (state_d == REJECT);
            ready_q   <= (state_d == IDLE);
        end
    end

    // Next-state logic: validate, then walk MARK/ACK/GAP once per unit.
    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        units_d   = units_q;
        gapCnt_d  = gapCnt_q;
        overrun_d = overrun_q | (coinEvent && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (coinEvent) begin
                    val_d   = bus.coin_val;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((val_q == 2'd0) || (sum > CREDIT_LIM)) begin
                    state_d = REJECT;
                end else begin
                    units_d = val_q;
                    state_d = MARK;
                end
            end
            MARK: begin
                gapCnt_d = 3'd0;
                state_d  = ACK;
            end
            ACK: begin
                units_d = units_q - 2'd1;
                if (units_q == 2'd1) begin
                    state_d = WAIT_REL;
                end else if (GAP_CYCLES == 0) begin
                    state_d = MARK;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d = MARK;
                end else begin
                    gapCnt_d = gapCnt_q + 3'd1;
                end
            end
            REJECT: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!deb_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m       = m_q;
    assign bus.a       = a_q;
    assign bus.reject  = reject_q;
    assign bus.ready   = ready_q;
    assign bus.overrun = overrun_q;

endmodule
